// File: rtl/ex_mem_stage_reg_if.sv
// EX/MEM stage bus: the EX-side offer (in_*), the MEM-side entry (out_*)
// and their valid/ready handshakes.
//   master : EX stage / producer of in_*, consumer of out_* (drives out_ready)
//   slave  : the EX/MEM pipeline register itself
interface ex_mem_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid, in_ready;
  logic              in_branch, in_write_back, in_mem_read, in_mem_write, in_write_reg;
  logic [DATA_W-1:0] in_alu_out, in_rd2, in_next_pc;
  logic [REG_AW-1:0] in_dst;
  logic              in_zero;

  logic              out_valid, out_ready;
  logic              out_branch, out_write_back, out_mem_read, out_mem_write, out_write_reg;
  logic [DATA_W-1:0] out_alu_out, out_rd2, out_next_pc;
  logic [REG_AW-1:0] out_dst;
  logic              out_zero;

  modport master (
    output in_valid, in_branch, in_write_back, in_mem_read, in_mem_write, in_write_reg,
           in_alu_out, in_rd2, in_next_pc, in_dst, in_zero, out_ready,
    input  in_ready, out_valid, out_branch, out_write_back, out_mem_read, out_mem_write,
           out_write_reg, out_alu_out, out_rd2, out_next_pc, out_dst, out_zero
  );

  modport slave (
    input  in_valid, in_branch, in_write_back, in_mem_read, in_mem_write, in_write_reg,
           in_alu_out, in_rd2, in_next_pc, in_dst, in_zero, out_ready,
    output in_ready, out_valid, out_branch, out_write_back, out_mem_read, out_mem_write,
           out_write_reg, out_alu_out, out_rd2, out_next_pc, out_dst, out_zero
  );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with valid/ready handshake, flush and optional
// skid buffer.
//   clk   : pipeline clock, rising edge
//   rst_n : synchronous active-low reset
//   flush : squash output entry, skid entry and any input offered this cycle
//   bus   : slave side of ex_mem_stage_reg_if (in_* offer, out_* entry)
// SKID=1 : two entries (output + skid), in_ready registered (!skid_full).
// SKID=0 : one entry, in_ready = out_ready | !out_valid.
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SKID   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  ex_mem_stage_reg_if.slave bus
);

  typedef struct packed {
    logic              branch;
    logic              write_back;
    logic              mem_read;
    logic              mem_write;
    logic              write_reg;
    logic              zero;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] next_pc;
    logic [REG_AW-1:0] dst;
  } ent_t;

  ent_t in_ent;
  ent_t out_q, out_d;
  ent_t skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_full_q, skid_full_d;
  logic in_ready;
  logic accept, consume;

  assign in_ent = '{branch:     bus.in_branch,
                    write_back: bus.in_write_back,
                    mem_read:   bus.in_mem_read,
                    mem_write:  bus.in_mem_write,
                    write_reg:  bus.in_write_reg,
                    zero:       bus.in_zero,
                    alu_out:    bus.in_alu_out,
                    rd2:        bus.in_rd2,
                    next_pc:    bus.in_next_pc,
                    dst:        bus.in_dst};

  // in_ready is held low during reset; otherwise the skid variant depends
  // only on flop state, so no combinational path from out_ready exists.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = rst_n & ~skid_full_q;
    end else begin : g_noskid
      assign in_ready = rst_n & (bus.out_ready | ~out_valid_q);
    end
  endgenerate

  assign accept  = bus.in_valid & in_ready;
  assign consume = out_valid_q & bus.out_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (skid_full_q) begin
      // in_ready is low here, so only the skid -> output move can happen
      if (consume) begin
        out_d       = skid_q;
        skid_full_d = 1'b0;
      end
    end else if (!out_valid_q || consume) begin
      out_valid_d = accept;
      if (accept) out_d = in_ent;
    end else if (accept && (SKID != 0)) begin
      // output stalled: park the new entry behind it
      skid_d      = in_ent;
      skid_full_d = 1'b1;
    end
    // a bubble must never carry live control; data fields keep their value
    if (!out_valid_d) begin
      out_d.branch     = 1'b0;
      out_d.write_back = 1'b0;
      out_d.mem_read   = 1'b0;
      out_d.mem_write  = 1'b0;
      out_d.write_reg  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_branch     = out_q.branch;
  assign bus.out_write_back = out_q.write_back;
  assign bus.out_mem_read   = out_q.mem_read;
  assign bus.out_mem_write  = out_q.mem_write;
  assign bus.out_write_reg  = out_q.write_reg;
  assign bus.out_zero       = out_q.zero;
  assign bus.out_alu_out    = out_q.alu_out;
  assign bus.out_rd2        = out_q.rd2;
  assign bus.out_next_pc    = out_q.next_pc;
  assign bus.out_dst        = out_q.dst;

endmodule
